// File: rtl/aud_recorder.sv
// Left-channel I2S capture for the lab3 audio path: deserializes one word per
// LRC frame and streams it into SRAM at consecutive addresses.
module aud_recorder #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16,
  parameter logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}}
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic              i_lrc,
  input  logic              i_data,
  output logic [ADDR_W-1:0] o_address,
  output logic [DATA_W-1:0] o_data,
  output logic              o_wr_en,
  output logic              o_busy,
  output logic              o_full,
  output logic [ADDR_W-1:0] o_last_addr,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_SHIFT = 3'd2,
    S_WRITE = 3'd3,
    S_PAUSE = 3'd4
  } state_t;

  localparam int CNT_W = $clog2(DATA_W);

  state_t            state;
  logic              lrc_q;
  logic              pend;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shift;
  logic [DATA_W-1:0] shift_nx;
  logic              lrc_fall;

  // Falling LRC marks the start of the left half; the MSB follows one BCLK later.
  assign lrc_fall  = ~i_lrc & lrc_q;
  assign shift_nx  = {shift[DATA_W-2:0], i_data};
  assign o_busy    = (state != S_IDLE);
  assign dbg_state = state;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_IDLE;
      lrc_q       <= 1'b0;
      pend        <= 1'b0;
      cnt         <= '0;
      shift       <= '0;
      o_address   <= '0;
      o_data      <= '0;
      o_wr_en     <= 1'b0;
      o_full      <= 1'b0;
      o_last_addr <= '0;
    end else begin
      lrc_q   <= i_lrc;
      o_wr_en <= 1'b0;
      if (i_stop && state != S_IDLE) begin
        // Abort drops any partial word; address and last address are kept.
        state <= S_IDLE;
        pend  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (i_start && !i_pause && !i_stop) begin
              state     <= S_WAIT;
              o_address <= '0;
              o_full    <= 1'b0;
            end
          end
          S_WAIT: begin
            if (i_pause) begin
              state <= S_PAUSE;
            end else if (lrc_fall) begin
              state <= S_SHIFT;
              cnt   <= '0;
            end
          end
          S_SHIFT: begin
            if (i_pause) pend <= 1'b1;
            if (lrc_fall) begin
              cnt <= '0;
            end else begin
              shift <= shift_nx;
              cnt   <= cnt + 1'b1;
              if (cnt == CNT_W'(DATA_W - 1)) begin
                state       <= S_WRITE;
                o_wr_en     <= 1'b1;
                o_data      <= shift_nx;
                o_last_addr <= o_address;
              end
            end
          end
          S_WRITE: begin
            pend <= 1'b0;
            if (o_address == MAX_ADDR) begin
              o_full <= 1'b1;
              state  <= S_IDLE;
            end else begin
              o_address <= o_address + 1'b1;
              state     <= (pend || i_pause) ? S_PAUSE : S_WAIT;
            end
          end
          S_PAUSE: begin
            if (i_start && !i_pause) state <= S_WAIT;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aud_recorder.sv
// Frame-level bench for aud_recorder: drives 50-cycle LRC frames with random
// words and control events, and predicts each SRAM write per frame.
module tb_aud_recorder;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;
  localparam logic [ADDR_W-1:0] MAX_ADDR = 4'd3;
  localparam int EW = 32 + ADDR_W + DATA_W;

  localparam int EV_NONE  = 0;
  localparam int EV_START = 1;
  localparam int EV_PAUSE = 2;
  localparam int EV_STOP  = 3;
  localparam int EV_STOPP = 4;
  localparam int EV_RST   = 5;

  logic clk = 1'b0;
  logic rst, start, pause, stop, lrc, data;
  logic [ADDR_W-1:0] address, last_addr;
  logic [DATA_W-1:0] wdata;
  logic wr_en, busy, full;
  logic [2:0] dbg_state;

  aud_recorder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_ADDR(MAX_ADDR)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_pause(pause), .i_stop(stop),
    .i_lrc(lrc), .i_data(data), .o_address(address), .o_data(wdata),
    .o_wr_en(wr_en), .o_busy(busy), .o_full(full), .o_last_addr(last_addr),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_bad = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every strobe must match the next predicted write exactly
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_wr", 1, 0);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check("wr_cycle", 64'(cyc), 64'(e[EW-1 -: 32]));
        check("wr_addr", 64'(address), 64'(e[ADDR_W+DATA_W-1 -: ADDR_W]));
        check("wr_data", 64'(wdata), 64'(e[DATA_W-1:0]));
      end
    end
  end

  // reference model: recorder mode per frame (0 idle, 1 recording, 2 paused)
  int m_mode = 0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [ADDR_W-1:0] m_last = '0;
  logic [DATA_W-1:0] m_data = '0;
  logic m_full = 1'b0;

  task automatic model_frame(input logic [DATA_W-1:0] word, input int ev, input int ev_k,
                             input int e_cyc);
    bit stop_early;
    stop_early = (ev == EV_STOP || ev == EV_STOPP) && ev_k < 17;
    if (ev == EV_RST) begin
      m_mode = 0; m_addr = '0; m_last = '0; m_data = '0; m_full = 1'b0;
      return;
    end
    if (m_mode == 1 && !stop_early) begin
      exp_q.push_back({32'(e_cyc + DATA_W + 1), m_addr, word});
      m_last = m_addr;
      m_data = word;
      if (m_addr == MAX_ADDR) begin
        m_full = 1'b1;
        m_mode = 0;
      end else begin
        m_addr = m_addr + 1'b1;
        if (ev == EV_PAUSE && ev_k < 17) m_mode = 2;
      end
    end else if (stop_early) begin
      m_mode = 0;
    end
    if (ev_k > 17) begin
      case (ev)
        EV_STOP, EV_STOPP: m_mode = 0;
        EV_PAUSE: if (m_mode == 1) m_mode = 2;
        EV_START: begin
          if (m_mode == 0) begin
            m_mode = 1; m_addr = '0; m_full = 1'b0;
          end else if (m_mode == 2) begin
            m_mode = 1;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'(m_mode != 0));
    check({tag, "_full"}, 64'(full), 64'(m_full));
    check({tag, "_addr"}, 64'(address), 64'(m_addr));
    check({tag, "_last"}, 64'(last_addr), 64'(m_last));
    check({tag, "_data"}, 64'(wdata), 64'(m_data));
    check({tag, "_pend_wr"}, 64'(exp_q.size()), 0);
  endtask

  // driver: one LRC frame; k=0 is the falling-edge cycle, left word on k=1..16
  task automatic run_frame(input string tag, input logic [DATA_W-1:0] word,
                           input int ev, input int ev_k);
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      #1;
      lrc   = (k < 25) ? 1'b0 : 1'b1;
      data  = (k >= 1 && k <= DATA_W) ? word[DATA_W-k] : 1'($urandom_range(0, 1));
      start = (ev == EV_START && k == ev_k);
      pause = ((ev == EV_PAUSE || ev == EV_STOPP) && k == ev_k);
      stop  = ((ev == EV_STOP || ev == EV_STOPP) && k == ev_k);
      rst   = (ev == EV_RST && k == ev_k);
      if (k == 0) model_frame(word, ev, ev_k, cyc);
      @(negedge clk);
      if (k == ev_k + 1 && (ev == EV_STOP || ev == EV_STOPP)) begin
        check({tag, "_stop_busy"}, 64'(busy), 0);
      end
      if (k == ev_k + 1 && ev == EV_RST) begin
        check({tag, "_rst_out"}, {address, wdata, wr_en, busy, full, last_addr}, 0);
      end
    end
    check_state(tag);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0; lrc = 1'b1; data = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_out", {address, wdata, wr_en, busy, full, last_addr}, 0);
    check("reset_state", 64'(dbg_state), 0);
    repeat (2) @(posedge clk);

    // basic capture
    run_frame("arm", 16'h1234, EV_START, 30);
    run_frame("basic", 16'hA5C3, EV_NONE, 0);
    // streaming up to the full boundary, then one ignored frame
    run_frame("rearm", 16'hFFFF, EV_START, 30);
    run_frame("stream0", 16'h0001, EV_NONE, 0);
    run_frame("stream1", 16'h0002, EV_NONE, 0);
    run_frame("stream2", 16'h0003, EV_NONE, 0);
    run_frame("full3", 16'h8001, EV_NONE, 0);
    run_frame("after_full", 16'h7777, EV_NONE, 0);
    // pause mid-sample
    run_frame("p_arm", 16'h0000, EV_START, 30);
    run_frame("p_s1", 16'h1111, EV_NONE, 0);
    run_frame("p_s2", 16'h2222, EV_PAUSE, 5);
    for (int i = 0; i < 3; i++) run_frame("p_idle", 16'($urandom), EV_NONE, 0);
    run_frame("p_resume", 16'h3333, EV_START, 30);
    run_frame("p_s3", 16'h4444, EV_NONE, 0);
    // stop mid-sample, then restart from address 0
    run_frame("s_stop", 16'h5555, EV_STOP, 8);
    run_frame("s_arm", 16'h6666, EV_START, 30);
    run_frame("s_s0", 16'h6789, EV_NONE, 0);
    // reset mid-shift, then simultaneous stop and pause
    run_frame("r_rst", 16'h9ABC, EV_RST, 10);
    run_frame("r_arm", 16'h0F0F, EV_START, 30);
    run_frame("r_stopp", 16'hF0F0, EV_STOPP, 6);
    run_frame("r_arm2", 16'h0F0F, EV_START, 30);
    run_frame("r_s0", 16'hBEEF, EV_NONE, 0);

    // randomized frames
    for (int i = 0; i < 40; i++) begin
      int r, ev, kk;
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: begin ev = EV_START; kk = $urandom_range(18, 48); end
        3:       begin ev = EV_PAUSE; kk = $urandom_range(1, 16); end
        4:       begin ev = EV_PAUSE; kk = $urandom_range(18, 48); end
        5:       begin ev = EV_STOP;  kk = $urandom_range(1, 16); end
        6:       begin ev = EV_STOP;  kk = $urandom_range(18, 48); end
        7:       begin ev = EV_STOPP; kk = $urandom_range(1, 16); end
        8:       begin ev = (i % 4 == 0) ? EV_RST : EV_NONE; kk = $urandom_range(1, 16); end
        default: begin ev = EV_NONE;  kk = 0; end
      endcase
      run_frame("rand", 16'($urandom), ev, kk);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
